// File: rtl/bist_pkg.sv
// Shared definitions for the BIST signature checker: the controller state
// encoding and the default MISR polynomial/seed values.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_REPORT  = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    // Round counter is fixed at 16 bits and saturates at all-ones.
    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/bist_misr_core.sv
// Multiple-input signature register. A load returns the register to the
// seed and takes priority over compaction.
// Each compaction shifts left once, XORs in the polynomial when the MSB
// falls out, and XORs in the response word.
module bist_misr_core
    import bist_pkg::*;
#(
    parameter int               Width = 16,
    parameter logic [Width-1:0] Poly  = Width'(DEFAULT_POLY),
    parameter logic [Width-1:0] Seed  = Width'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             load,
    input  logic             en,
    input  logic [Width-1:0] dataIn,
    output logic [Width-1:0] sig
);

    logic [Width-1:0] sig_q;
    logic [Width-1:0] sig_d;

    // Next signature: the seed on load, otherwise one MISR step when enabled.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = Seed;
        end else if (en) begin
            sig_d = {sig_q[Width-2:0], 1'b0}
                  ^ (sig_q[Width-1] ? Poly : {Width{1'b0}})
                  ^ dataIn;
        end
    end

    // Signature register. The load path doubles as the reset path.
    always_ff @(posedge clk) begin
        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_sig_checker.sv
// BIST signature checker. It compacts CUT responses into a MISR while the
// test controller runs. When done is raised, it compares the final
// signature with GoldenSig and holds a pass/fail verdict until the next
// session start (clr) or reset.
// Optional feature macro: BIST_ROUND_CHECK_EN. When this macro is defined,
// a pass also requires exactly numOfRounds compaction pulses.
module bist_sig_checker
    import bist_pkg::*;
#(
    parameter int               Width       = 16,
    parameter logic [Width-1:0] Poly        = Width'(DEFAULT_POLY),
    parameter logic [Width-1:0] Seed        = Width'(DEFAULT_SEED),
    parameter logic [Width-1:0] GoldenSig   = '0,
    parameter int               numOfRounds = 50
) (
    input  logic             clk,
    input  logic             rstIn,
    input  logic             clr,
    input  logic             MISR_En,
    input  logic [Width-1:0] dataIn,
    input  logic             done,
    output logic [Width-1:0] sigOut,
    output logic             valid,
    output logic             pass,
    output logic             fail
);

`ifdef BIST_ROUND_CHECK_EN
    localparam logic RoundCheck = 1'b1;
`else
    // In this build the counter feeds only a constant-false term.
    // Synthesis therefore removes it.
    localparam logic RoundCheck = 1'b0;
`endif

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             compact_en;
    logic             misr_load;
    logic             match;

    // Compaction happens only in COMPACT, and a same-cycle clr wins over it.
    // A MISR_En that arrives together with done is still compacted.
    assign compact_en = (state_q == ST_COMPACT) && MISR_En && !clr;
    assign misr_load  = rstIn || clr;

    bist_misr_core #(
        .Width (Width),
        .Poly  (Poly),
        .Seed  (Seed)
    ) u_misr (
        .clk    (clk),
        .load   (misr_load),
        .en     (compact_en),
        .dataIn (dataIn),
        .sig    (sigOut)
    );

    // The verdict compares the registered signature seen during COMPARE.
    // When the round check is enabled, it also compares the round count.
    assign match = (sigOut == GoldenSig) &&
                   (!RoundCheck || (count_q == CNT_W'(numOfRounds)));

    // Next-state logic for the session FSM, the verdict and the round counter.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        count_d = count_q;
        if (clr) begin
            state_d = ST_COMPACT;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            count_d = '0;
        end else begin
            if (compact_en && (count_q != CNT_MAX)) begin
                count_d = count_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COMPACT: begin
                    if (done) begin
                        state_d = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    state_d = ST_REPORT;
                    valid_d = 1'b1;
                    pass_d  = match;
                    fail_d  = !match;
                end
                ST_REPORT: begin
                    state_d = ST_REPORT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and verdict registers. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rstIn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            count_q <= count_d;
        end
    end

    assign valid = valid_q;
    assign pass  = pass_q;
    assign fail  = fail_q;

endmodule
